// File: rtl/core_mem_responder.sv
`default_nettype none
// core_mem_responder: responder end of a core data-memory bus with a local RAM,
// programmable response latency, a one-cycle ready pulse and host-side preload.
module core_mem_responder #(
  parameter int REG_SIZE  = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           enable,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [REG_SIZE-1:0]  wr_data,
  output logic [REG_SIZE-1:0]  rd_data,
  output logic                 ready_sig,
  input  logic                 init_we,
  input  logic [ADDR_SIZE-1:0] init_addr,
  input  logic [REG_SIZE-1:0]  init_data,
  output logic                 busy,
  output logic                 err
);

  localparam int                 IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [3:0]         LAT_C   = 4'(LATENCY);
  localparam logic [1:0]         EN_IDLE = 2'b00;
  localparam logic [1:0]         EN_RD   = 2'b01;
  localparam logic [1:0]         EN_WR   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [1:0]           req_type_q;
  logic [ADDR_SIZE-1:0] req_addr_q;
  logic [REG_SIZE-1:0]  req_wdata_q;
  logic [REG_SIZE-1:0]  rd_data_q;
  logic                 ready_q;
  logic                 err_q;

  logic [REG_SIZE-1:0]  mem_q [MEM_DEPTH];

  logic                 req_in_range;
  logic                 init_in_range;
  logic                 access_now;
  logic                 ram_we;
  logic [IDX_W-1:0]     ram_widx;
  logic [REG_SIZE-1:0]  ram_wdata;

  assign req_in_range  = {1'b0, req_addr_q} < DEPTH_C;
  assign init_in_range = {1'b0, init_addr} < DEPTH_C;
  assign access_now    = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // The core write and the host preload are mutually exclusive by state.
  always_comb begin
    ram_we    = 1'b0;
    ram_widx  = init_addr[IDX_W-1:0];
    ram_wdata = init_data;
    if (access_now && (req_type_q == EN_WR) && req_in_range) begin
      ram_we    = 1'b1;
      ram_widx  = req_addr_q[IDX_W-1:0];
      ram_wdata = req_wdata_q;
    end else if ((state_q == S_IDLE) && (enable == EN_IDLE) && init_we && init_in_range) begin
      ram_we    = 1'b1;
    end
  end

  // RAM contents survive reset; writes are simply suppressed while it is held.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      mem_q[ram_widx] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_type_q  <= 2'b00;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rd_data_q   <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable != EN_IDLE) begin
            req_type_q  <= enable;
            req_addr_q  <= addr;
            req_wdata_q <= wr_data;
            cnt_q       <= LAT_C;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            case (req_type_q)
              EN_RD: begin
                if (req_in_range) begin
                  rd_data_q <= mem_q[req_addr_q[IDX_W-1:0]];
                end else begin
                  rd_data_q <= '0;
                  err_q     <= 1'b1;
                end
              end
              EN_WR: begin
                if (!req_in_range) begin
                  err_q <= 1'b1;
                end
              end
              default: begin
                rd_data_q <= '0;
                err_q     <= 1'b1;
              end
            endcase
          end
        end
        S_RESP: begin
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (enable == EN_IDLE) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign ready_sig = ready_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
// Bench for core_mem_responder: instance A (LATENCY=2, 16 words), instance B (LATENCY=0, 256 words).
module tb_core_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] a_en,  b_en;
  logic [7:0] a_addr, b_addr, a_wd, b_wd, a_rd, b_rd;
  logic       a_ready, b_ready, a_busy, b_busy, a_err, b_err;
  logic       a_iwe, b_iwe;
  logic [7:0] a_iaddr, b_iaddr, a_idata, b_idata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  core_mem_responder #(.REG_SIZE(8), .ADDR_SIZE(8), .MEM_DEPTH(16), .LATENCY(2)) u_a (
    .clk(clk), .reset(rst_n), .enable(a_en), .addr(a_addr), .wr_data(a_wd),
    .rd_data(a_rd), .ready_sig(a_ready), .init_we(a_iwe), .init_addr(a_iaddr),
    .init_data(a_idata), .busy(a_busy), .err(a_err)
  );

  core_mem_responder #(.REG_SIZE(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .LATENCY(0)) u_b (
    .clk(clk), .reset(rst_n), .enable(b_en), .addr(b_addr), .wr_data(b_wd),
    .rd_data(b_rd), .ready_sig(b_ready), .init_we(b_iwe), .init_addr(b_iaddr),
    .init_data(b_idata), .busy(b_busy), .err(b_err)
  );

  // Counts edges from the request edge (edge 0) until ready is seen; pops the expected word.
  task automatic wait_ready(input bit sel, input int max_cyc, output int cyc,
                            output bit busy_ok, output logic [7:0] ev);
    cyc     = -1;
    busy_ok = 1'b1;
    ev      = 'x;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (!(sel ? b_busy : a_busy)) busy_ok = 1'b0;
      if (sel ? b_ready : a_ready) begin
        cyc = i;
        break;
      end
    end
    if (sel) begin
      if (exp_b.size() > 0) ev = exp_b.pop_front();
    end else if (exp_a.size() > 0) begin
      ev = exp_a.pop_front();
    end
  endtask

  task automatic release_bus(input bit sel);
    @(negedge clk);
    if (sel) b_en = 2'b00; else a_en = 2'b00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic preload_a(input logic [7:0] ad, input logic [7:0] d);
    @(negedge clk);
    a_iwe = 1'b1; a_iaddr = ad; a_idata = d;
    @(negedge clk);
    a_iwe = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (a_rd !== 8'h00) $display("FAIL reset_rd: got %h want 00", a_rd); else n_pass++;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_ready); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL reset_err: got %b want 0", a_err); else n_pass++;
    n_checks++;
    if ({b_rd, b_ready, b_busy, b_err} !== 11'h0)
      $display("FAIL reset_b: got %h want 000", {b_rd, b_ready, b_busy, b_err});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preload_read;
    int cyc; bit bok; logic [7:0] ev;
    preload_a(8'd5, 8'hA7);
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd5;
    exp_a.push_back(8'hA7);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (cyc !== 3) $display("FAIL lat2_cycles: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL lat2_busy: got %b want 1", bok); else n_pass++;
    n_checks++; if (a_rd !== ev) $display("FAIL lat2_rd: got %h want %h", a_rd, ev); else n_pass++;
  endtask

  // Continues from the RESP cycle of the previous read with enable still held.
  task automatic test_hold_release;
    int extra = 0; int nb = 0; int cyc; bit bok; logic [7:0] ev;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (a_ready) extra++;
      if (!a_busy) nb++;
    end
    n_checks++; if (extra !== 0) $display("FAIL hold_pulses: got %0d extra want 0", extra); else n_pass++;
    n_checks++; if (nb !== 0) $display("FAIL hold_busy: got %0d idle cycles want 0", nb); else n_pass++;
    n_checks++; if (a_rd !== 8'hA7) $display("FAIL hold_rd: got %h want a7", a_rd); else n_pass++;
    @(negedge clk);
    a_en = 2'b00;
    @(posedge clk); #1;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL release_idle: got %b want 0", a_busy); else n_pass++;
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd5;
    exp_a.push_back(8'hA7);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (cyc !== 3) $display("FAIL next_req_cycles: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (a_rd !== ev) $display("FAIL next_req_rd: got %h want %h", a_rd, ev); else n_pass++;
    release_bus(0);
  endtask

  task automatic test_latency0;
    int cyc; bit bok; logic [7:0] ev;
    @(negedge clk);
    b_en = 2'b10; b_addr = 8'd9; b_wd = 8'h3C;
    exp_b.push_back(8'h00);
    wait_ready(1, 10, cyc, bok, ev);
    n_checks++; if (cyc !== 1) $display("FAIL lat0_wr_cycles: got %0d want 1", cyc); else n_pass++;
    n_checks++; if (b_rd !== ev) $display("FAIL lat0_wr_rd: got %h want %h", b_rd, ev); else n_pass++;
    release_bus(1);
    @(negedge clk);
    b_en = 2'b01; b_addr = 8'd9; b_wd = 8'h00;
    exp_b.push_back(8'h3C);
    wait_ready(1, 10, cyc, bok, ev);
    n_checks++; if (cyc !== 1) $display("FAIL lat0_rd_cycles: got %0d want 1", cyc); else n_pass++;
    n_checks++; if (b_rd !== ev) $display("FAIL lat0_rd: got %h want %h", b_rd, ev); else n_pass++;
    release_bus(1);
  endtask

  task automatic test_out_of_range;
    int cyc; bit bok; logic [7:0] ev;
    preload_a(8'd4, 8'h12);
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd20;
    exp_a.push_back(8'h00);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL oor_rd: got %h want %h", a_rd, ev); else n_pass++;
    n_checks++; if (a_err !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", a_err); else n_pass++;
    release_bus(0);
    @(negedge clk);
    a_en = 2'b10; a_addr = 8'd20; a_wd = 8'h77;
    exp_a.push_back(8'h00);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL oor_wr_rd: got %h want %h", a_rd, ev); else n_pass++;
    n_checks++; if (a_err !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", a_err); else n_pass++;
    release_bus(0);
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd4;
    exp_a.push_back(8'h12);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL oor_no_alias: got %h want %h", a_rd, ev); else n_pass++;
    release_bus(0);
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd5;
    exp_a.push_back(8'hA7);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL oor_then_valid: got %h want %h", a_rd, ev); else n_pass++;
    n_checks++; if (a_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", a_err); else n_pass++;
    release_bus(0);
  endtask

  task automatic test_reset_mid;
    int seen = 0; int cyc; bit bok; logic [7:0] ev;
    preload_a(8'd3, 8'h11);
    @(negedge clk);
    a_en = 2'b10; a_addr = 8'd3; a_wd = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_rd !== 8'h00) $display("FAIL mid_rst_rd: got %h want 00", a_rd); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", a_err); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", a_busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_ready) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_rst_ready: got %0d pulses want 0", seen); else n_pass++;
    @(negedge clk);
    a_en = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd3;
    exp_a.push_back(8'h11);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL mid_rst_ram: got %h want %h", a_rd, ev); else n_pass++;
    release_bus(0);
  endtask

  task automatic test_collision_reserved;
    int cyc; bit bok; logic [7:0] ev;
    @(negedge clk);
    a_en = 2'b10; a_addr = 8'd4; a_wd = 8'h55;
    a_iwe = 1'b1; a_iaddr = 8'd4; a_idata = 8'hFF;
    exp_a.push_back(8'h11);
    wait_ready(0, 20, cyc, bok, ev);
    a_iwe = 1'b0;
    n_checks++; if (a_rd !== ev) $display("FAIL collide_wr_rd: got %h want %h", a_rd, ev); else n_pass++;
    release_bus(0);
    @(negedge clk);
    a_en = 2'b01; a_addr = 8'd4;
    exp_a.push_back(8'h55);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (a_rd !== ev) $display("FAIL collide_ram: got %h want %h", a_rd, ev); else n_pass++;
    release_bus(0);
    @(negedge clk);
    a_en = 2'b11; a_addr = 8'd2;
    exp_a.push_back(8'h00);
    wait_ready(0, 20, cyc, bok, ev);
    n_checks++; if (cyc !== 3) $display("FAIL rsvd_cycles: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (a_rd !== ev) $display("FAIL rsvd_rd: got %h want %h", a_rd, ev); else n_pass++;
    n_checks++; if (a_err !== 1'b1) $display("FAIL rsvd_err: got %b want 1", a_err); else n_pass++;
    release_bus(0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 2'b00; a_addr = '0; a_wd = '0; a_iwe = 1'b0; a_iaddr = '0; a_idata = '0;
    b_en = 2'b00; b_addr = '0; b_wd = '0; b_iwe = 1'b0; b_iaddr = '0; b_idata = '0;
    test_reset();
    test_preload_read();
    test_hold_release();
    test_latency0();
    test_out_of_range();
    test_reset_mid();
    test_collision_reserved();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
